// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - issue/result bundle between decode/EX and the mul/div unit
interface ex_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stallreq;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  stallreq, busy, done, hilo_we, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output stallreq, busy, done, hilo_we, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage iterative mult/multu/div/divu unit; MULDIV_FAST_MUL_EN selects single-cycle multiply
module ex_muldiv (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_signed, is_div, a_neg, b_neg, b_zero;
    logic [31:0] abs_a, abs_b;
    logic [32:0] div_trial;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [31:0] quo_fix, rem_fix;

    assign is_signed = ~bus.op[0];
    assign is_div    = bus.op[1];
    assign a_neg     = is_signed & bus.src_a[31];
    assign b_neg     = is_signed & bus.src_b[31];
    assign b_zero    = (bus.src_b == 32'd0);
    assign abs_a     = a_neg ? -bus.src_a : bus.src_a;
    assign abs_b     = b_neg ? -bus.src_b : bus.src_b;

    // acc holds {remainder, dividend/quotient}; quotient bits shift in at the bottom
    assign div_trial = acc_q[63:31];
    assign div_ge    = (div_trial >= {1'b0, opnd_q});
    assign div_diff  = div_trial[31:0] - opnd_q;
    assign div_next  = {(div_ge ? div_diff : div_trial[31:0]), acc_q[30:0], div_ge};
    assign quo_fix   = neg_lo_q ? -div_next[31:0]  : div_next[31:0];
    assign rem_fix   = neg_hi_q ? -div_next[63:32] : div_next[63:32];

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] prod_fast;
    assign prod_fast = (a_neg ^ b_neg) ? -({32'd0, abs_a} * {32'd0, abs_b})
                                       :  ({32'd0, abs_a} * {32'd0, abs_b});
`else
    logic [32:0] mul_sum;
    logic [63:0] mul_next, prod_fix;
    // acc holds {partial product, multiplier}; multiplier bits consumed LSB first
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};
    assign prod_fix = neg_lo_q ? -mul_next : mul_next;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d    = 5'd31;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    if (is_div) begin
                        state_d = DIV;
                        // divide by zero runs raw: all-ones quotient and remainder = src_a fall out
                        acc_d   = {32'd0, (b_zero ? bus.src_a : abs_a)};
                        opnd_d  = abs_b;
                        if (b_zero) begin
                            neg_lo_d = 1'b0;
                            neg_hi_d = 1'b0;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_d      = DONE;
                        {hi_d, lo_d} = prod_fast;
`else
                        state_d = MUL;
                        acc_d   = {32'd0, abs_b};
                        opnd_d  = abs_a;
`endif
                    end
                end
            end
`ifndef MULDIV_FAST_MUL_EN
            MUL: begin
                acc_d = mul_next;
                if (cnt_q == 5'd0) begin
                    {hi_d, lo_d} = prod_fix;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
`endif
            DIV: begin
                acc_d = div_next;
                if (cnt_q == 5'd0) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.cancel) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.stallreq = rst & (((state_q == IDLE) & bus.start) | (state_q == MUL) | (state_q == DIV));
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.hilo_we  = (state_q == DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    ex_muldiv_if bus ();
    ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue one cycle after the previous op's DONE; sample on falling edges
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat);
        int lat;
        int stalls;
        @(negedge clk);
        check1({tag, " idle before issue"}, bus.busy, 1'b0);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        lat    = 0;
        stalls = 0;
        #1;
        while (!bus.done && lat < 100) begin
            if (bus.stallreq) stalls++;
            @(negedge clk);
            lat++;
        end
        if (bus.stallreq) stalls++;
        bus.start = 1'b0;
        check32({tag, " latency"}, lat, elat);
        check32({tag, " stall cycles"}, stalls, elat);
        check1({tag, " hilo_we"}, bus.hilo_we, 1'b1);
        check32({tag, " hi"}, bus.hi, ehi);
        check32({tag, " lo"}, bus.lo, elo);
    endtask

    initial begin
        int   lat;
        logic seen;

        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check1("reset busy", bus.busy, 1'b0);
        check1("reset done", bus.done, 1'b0);
        check1("reset stallreq", bus.stallreq, 1'b0);
        check32("reset hi", bus.hi, 32'd0);
        check32("reset lo", bus.lo, 32'd0);
        rst = 1'b1;

        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("mult -1*2", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("multu ffffffff*2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mult -2*-3", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, MUL_LAT);
        run_op("div neg/0", 2'b10, 32'h8000_0005, 32'd0, 32'h8000_0005, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu x/0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, DIV_LAT);

        // cancel at DIV cycle 10
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        repeat (10) @(negedge clk);
        check1("cancel busy before", bus.busy, 1'b1);
        bus.cancel = 1'b1;
        bus.start  = 1'b0;
        @(negedge clk);
        bus.cancel = 1'b0;
        check1("cancel busy after", bus.busy, 1'b0);
        check1("cancel stallreq after", bus.stallreq, 1'b0);
        check32("cancel hi kept", bus.hi, 32'h1234_5678);
        check32("cancel lo kept", bus.lo, 32'hFFFF_FFFF);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check1("cancel no done", seen, 1'b0);

        // start pulsed with different operands while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 6;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check32("pulse latency", lat, DIV_LAT);
        check32("pulse hi", bus.hi, 32'd2);
        check32("pulse lo", bus.lo, 32'd14);

        // reset at DIV cycle 20
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd500; bus.src_b = 32'd9;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check1("midrst busy", bus.busy, 1'b0);
        check1("midrst done", bus.done, 1'b0);
        check1("midrst hilo_we", bus.hilo_we, 1'b0);
        check1("midrst stallreq", bus.stallreq, 1'b0);
        check32("midrst hi", bus.hi, 32'd0);
        check32("midrst lo", bus.lo, 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
        run_op("multu b2b", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, MUL_LAT);
        @(negedge clk);
        check1("final idle", bus.busy, 1'b0);
        check1("final done low", bus.done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage, directly downstream of instruction decode. Accepts MIPS mult/multu/div/divu with both register operands already forwarded by decode. Holds the pipeline through `stallreq` while an operation is in flight. Delivers a 64-bit {HI, LO} result with a one-cycle write strobe toward the HI/LO registers.

## Interface
- No parameters.
- `clk` in 1: pipeline clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: a mul/div instruction is valid in EX this cycle.
- `op` in 2: operation select.
  - 2'b00 mult, 2'b01 multu, 2'b10 div, 2'b11 divu.
- `src_a` in 32: rs value (dividend / multiplicand).
- `src_b` in 32: rt value (divisor / multiplier).
- `cancel` in 1: synchronous abort of the in-flight operation.
- `stallreq` out 1: request a pipeline hold, IF through EX.
- `busy` out 1: state is not IDLE.
- `done` out 1: result valid this cycle.
- `hilo_we` out 1: write HI and LO; equal to `done`.
- `hi` out 32: HI result; remainder for div.
- `lo` out 32: LO result; quotient for div.

## Operation
- States:
  - IDLE: waiting for an operation.
  - MUL: iterative multiply (iterative build only).
  - DIV: iterative divide.
  - DONE: result presented.
- IDLE, `start`=1:
  - Latch `op`, |src_a|, |src_b| (magnitudes for signed ops only) and the result sign flags.
  - Load the 5-bit iteration counter with 31.
  - Go to DIV (div/divu) or MUL (mult/multu; fast build goes straight to DONE).
- `start` while not IDLE: ignored. The pipeline holds `start`/`op`/operands stable while stalled.
- DIV is restoring, 1 quotient bit per cycle, MSB first:
  - 33-bit partial remainder.
  - Subtract when remainder ≥ divisor.
- MUL is shift-add on magnitudes, 1 bit per cycle, with a 64-bit accumulator.
- Counter = 0 in MUL/DIV: next edge loads `hi`/`lo` with the sign-corrected result and goes to DONE.
- Signed sign rules:
  - Product negated iff operand signs differ (64-bit two's complement).
  - Quotient negated iff signs differ.
  - Remainder takes the dividend's sign.
- Corner cases:
  - 0x8000_0000 / 0xFFFF_FFFF (div): LO=0x8000_0000, HI=0.
  - Divide by zero (both div and divu): LO=0xFFFF_FFFF, HI=src_a, no sign fixup, normal latency.
- DONE: `done`=`hilo_we`=1 for exactly one cycle, then IDLE. `hi`/`lo` hold their value until the next result load.
- `cancel`=1 in any state: next edge goes to IDLE.
  - No `done`; `hi`/`lo` unchanged.
  - `cancel` has priority over `start` in the same cycle.
- Reset (asserted at any time, including mid-operation): state IDLE, counter 0, `hi`=`lo`=0, all outputs 0.

## Timing
- `stallreq` = (IDLE & `start`) | MUL | DIV. It is combinational from `start`, so the stall begins in the issue cycle.
- DONE never stalls. The instruction advances out of EX in the DONE cycle.
- Divide, issue in cycle C0:
  - DIV in C1..C32; `done` in C33.
  - `stallreq` high C0..C32 (33 cycles).
- Multiply, iterative build: same timing as divide.
- Multiply, fast build:
  - `done` in C1; `stallreq` high in C0 only.
- `busy` is registered: high in every non-IDLE cycle.
- After DONE the unit is back in IDLE, so a back-to-back mul/div can issue in C34.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - mult/multu use a single-cycle 32×32 array multiply.
  - MUL state is not implemented.
  - Latency as given under Timing (fast build).
- Undefined:
  - Iterative shift-add MUL state.
  - Multiply latency identical to divide.
- Division is iterative in both builds.

## Test plan
- divu src_a=100, src_b=7 -> `done` exactly 33 cycles after issue, LO=14, HI=2, `stallreq` high 33 cycles.
- div src_a=0xFFFF_FFF9 (-7), src_b=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- Multiply with src_a=0xFFFF_FFFF, src_b=2, run in both builds, checking latency per build:
  - mult -> HI=0xFFFF_FFFF, LO=0xFFFF_FFFE.
  - multu -> HI=0x0000_0001, LO=0xFFFF_FFFE.
- divu src_a=0x1234_5678, src_b=0 -> LO=0xFFFF_FFFF, HI=0x1234_5678, normal latency.
- Abort and busy behaviour:
  - `cancel` at DIV cycle 10 -> IDLE next cycle, no `done`, `hi`/`lo` unchanged.
  - `rst` low at DIV cycle 20 -> all outputs 0 immediately.
  - `start` pulsed while busy -> ignored, first result unchanged.
- div 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0; new op issued the cycle after DONE is accepted.
